// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants and the VRAM arbiter state encoding.
// Used by both the controller and the arbiter so geometry stays in one place.
package vga_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 3;
    localparam int VRAM_DEPTH  = 12288;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

endpackage

// File: rtl/vram_wr_buffer.sv
// One-entry holding register for pixel writes waiting for a free RAM cycle.
// A load wins over a drain in the same cycle, so the entry refills in place.
module vram_wr_buffer
    import vga_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              resetbutton_n,
    input  logic              load,
    input  logic              drain,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge resetbutton_n) begin
        if (!resetbutton_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= load_addr;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port frame-buffer RAM between scan-out reads (absolute
// priority), the clear-screen sequencer and a buffered pixel writer.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int                ADDR_W    = VRAM_ADDR_W,
    parameter int                DATA_W    = VRAM_DATA_W,
    parameter int                DEPTH     = VRAM_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              resetbutton_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_load;
    logic              buf_drain;
    logic              clr_write;
    logic              clr_last;

    vram_wr_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_buffer (
        .clk           (clk),
        .resetbutton_n (resetbutton_n),
        .load          (buf_load),
        .drain         (buf_drain),
        .load_addr     (wr_addr),
        .load_data     (wr_data),
        .full          (buf_full),
        .addr          (buf_addr),
        .data          (buf_data)
    );

    // Reset gates the outputs combinationally so the RAM sees nothing while held.
    always_comb begin
        clr_write = (state == CLEAR) && !rd_req;
        clr_last  = clr_write && (clr_cnt == LAST_ADDR);
        buf_drain = buf_full && !rd_req && (state != CLEAR);
        wr_ready  = resetbutton_n && (state == IDLE) && (!buf_full || !rd_req);
        buf_load  = wr_valid && wr_ready;
        clr_done  = resetbutton_n && clr_last;
        clr_busy  = (state != IDLE);
        rd_data   = mem_rdata;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!resetbutton_n) begin
            mem_en = 1'b0;
        end else if (rd_req) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (state == CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = CLEAR_VAL;
        end else if (buf_full) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = buf_addr;
            mem_wdata = buf_data;
        end
    end

    // A write accepted alongside clr_start must land before the clear overwrites it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = (buf_load || (buf_full && !buf_drain)) ? DRAIN : CLEAR;
                end
            end
            DRAIN: begin
                if (buf_drain) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetbutton_n) begin
        if (!resetbutton_n) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= rd_req;
            if (clr_write) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small behavioural RAM behind the port.
module tb_vram_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 3;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          resetbutton_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int checkCount = 0;
    int passCount  = 0;

    int clrWrites, clrOrderErr, clrDataErr, clrDones, clrReadErr, clrBusyErr;
    logic clrBusyAfter;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .CLEAR_VAL (3'b000)
    ) dut (
        .clk           (clk),
        .resetbutton_n (resetbutton_n),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .clr_done      (clr_done),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Synchronous single-port RAM: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic stepClk;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rr, input logic [AW-1:0] ra, input logic wv,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic cs);
        rd_req    = rr;
        rd_addr   = ra;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        clr_start = cs;
        #1;
    endtask

    // Runs an already-started clear to completion, reading every readEvery cycles (0 = never).
    task automatic runClear(input int readEvery);
        int   k;
        bit   done;
        logic rr;
        clrWrites = 0; clrOrderErr = 0; clrDataErr = 0;
        clrDones = 0; clrReadErr = 0; clrBusyErr = 0;
        k = 0;
        done = 1'b0;
        while (!done && k < 200) begin
            rr = (readEvery != 0) && (k % readEvery == 0);
            applyStimulus(rr, AW'(k), 1'b0, '0, '0, 1'b0);
            if (rr && !(mem_en && !mem_we && mem_addr == AW'(k))) clrReadErr++;
            if (!rr && mem_en && mem_we) begin
                if (mem_addr != AW'(clrWrites)) clrOrderErr++;
                if (mem_wdata != 3'b000) clrDataErr++;
                clrWrites++;
            end
            if (!clr_busy) clrBusyErr++;
            if (clr_done) begin
                clrDones++;
                done = 1'b1;
            end
            stepClk;
            k++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        clrBusyAfter = clr_busy;
        for (int i = 0; i < 3; i++) begin
            if (clr_done) clrDones++;
            stepClk;
        end
    endtask

    initial begin
        int readyHigh;
        int weDuring;
        int resetDones;

        for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
        ram[5]    = 3'b101;
        mem_rdata = '0;
        resetbutton_n = 1'b1;
        applyStimulus(1'b1, 14'd5, 1'b1, 14'd9, 3'b001, 1'b0);
        resetbutton_n = 1'b0;
        #1;
        checkOutput("reset_mem_en",   32'(mem_en),   32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_wr_ready", 32'(wr_ready), 32'd0);
        stepClk;
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_clr_busy", 32'(clr_busy), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        resetbutton_n = 1'b1;
        stepClk;

        // Read latency
        applyStimulus(1'b1, 14'd5, 1'b0, '0, '0, 1'b0);
        checkOutput("rd_mem_en",   32'(mem_en),   32'd1);
        checkOutput("rd_mem_we",   32'(mem_we),   32'd0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'd5);
        stepClk;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("rd_valid_1", 32'(rd_valid), 32'd1);
        checkOutput("rd_data_5",  32'(rd_data),  32'b101);
        stepClk;
        checkOutput("rd_valid_0", 32'(rd_valid), 32'd0);

        // Idle write then readback
        applyStimulus(1'b0, '0, 1'b1, 14'd100, 3'b011, 1'b0);
        checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);
        stepClk;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("idle_mem_we",    32'(mem_we),    32'd1);
        checkOutput("idle_mem_addr",  32'(mem_addr),  32'd100);
        checkOutput("idle_mem_wdata", 32'(mem_wdata), 32'b011);
        stepClk;
        applyStimulus(1'b1, 14'd100, 1'b0, '0, '0, 1'b0);
        stepClk;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("readback_100", 32'(rd_data), 32'b011);

        // Two writes offered while reads hold the RAM for 10 cycles
        applyStimulus(1'b1, '0, 1'b1, 14'd20, 3'b001, 1'b0);
        checkOutput("wur_first_ready", 32'(wr_ready), 32'd1);
        stepClk;
        readyHigh = 0;
        weDuring  = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, '0, 1'b1, 14'd21, 3'b010, 1'b0);
            if (wr_ready) readyHigh++;
            if (mem_we) weDuring++;
            stepClk;
        end
        checkOutput("wur_ready_held_low", 32'(readyHigh), 32'd0);
        checkOutput("wur_no_write",       32'(weDuring),  32'd0);
        applyStimulus(1'b0, '0, 1'b1, 14'd21, 3'b010, 1'b0);
        checkOutput("wur_drain_addr",  32'(mem_addr),  32'd20);
        checkOutput("wur_drain_data",  32'(mem_wdata), 32'b001);
        checkOutput("wur_refill_rdy",  32'(wr_ready),  32'd1);
        stepClk;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("wur_second_we",   32'(mem_we),    32'd1);
        checkOutput("wur_second_addr", 32'(mem_addr),  32'd21);
        checkOutput("wur_second_data", 32'(mem_wdata), 32'b010);
        stepClk;
        checkOutput("wur_idle_en", 32'(mem_en), 32'd0);

        // Clear with reads every third cycle
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        stepClk;
        runClear(3);
        checkOutput("clr3_writes",   32'(clrWrites),    32'd16);
        checkOutput("clr3_order",    32'(clrOrderErr),  32'd0);
        checkOutput("clr3_data",     32'(clrDataErr),   32'd0);
        checkOutput("clr3_reads",    32'(clrReadErr),   32'd0);
        checkOutput("clr3_dones",    32'(clrDones),     32'd1);
        checkOutput("clr3_busy",     32'(clrBusyErr),   32'd0);
        checkOutput("clr3_busy_end", 32'(clrBusyAfter), 32'd0);

        // Clear requested while the buffer holds addr 7
        applyStimulus(1'b1, '0, 1'b1, 14'd7, 3'b110, 1'b0);
        checkOutput("cfb_accept", 32'(wr_ready), 32'd1);
        stepClk;
        applyStimulus(1'b1, '0, 1'b0, '0, '0, 1'b1);
        stepClk;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("cfb_busy",       32'(clr_busy),  32'd1);
        checkOutput("cfb_drain_rdy",  32'(wr_ready),  32'd0);
        checkOutput("cfb_drain_addr", 32'(mem_addr),  32'd7);
        checkOutput("cfb_drain_data", 32'(mem_wdata), 32'b110);
        stepClk;
        runClear(0);
        checkOutput("cfb_writes", 32'(clrWrites),   32'd16);
        checkOutput("cfb_order",  32'(clrOrderErr), 32'd0);
        checkOutput("cfb_dones",  32'(clrDones),    32'd1);
        checkOutput("cfb_ram7",   32'(ram[7]),      32'd0);

        // Reset in the middle of a clear
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        stepClk;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
            stepClk;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("mid_clr_addr6", 32'(mem_addr), 32'd6);
        resetbutton_n = 1'b0;
        #1;
        checkOutput("rst_mid_en",   32'(mem_en),   32'd0);
        checkOutput("rst_mid_we",   32'(mem_we),   32'd0);
        checkOutput("rst_mid_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mid_busy", 32'(clr_busy), 32'd0);
        resetDones = 0;
        for (int i = 0; i < 2; i++) begin
            if (clr_done) resetDones++;
            stepClk;
        end
        checkOutput("rst_mid_no_done", 32'(resetDones), 32'd0);
        resetbutton_n = 1'b1;
        #1;
        checkOutput("rst_rel_ready", 32'(wr_ready), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        stepClk;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("restart_busy", 32'(clr_busy), 32'd1);
        checkOutput("restart_we",   32'(mem_we),   32'd1);
        checkOutput("restart_addr", 32'(mem_addr), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
